// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port 32-bit data memory with a req/ack handshake and a fixed
//   number of wait states per access. Each request is latched on
//   acceptance. The response is a one-cycle ack carrying rdata and err.
//   After each response there is one IDLE cycle before the next request
//   can be accepted.
//
// Parameters
//   WAIT_CYCLES  wait states before each response (0..7)
//   DEPTH_LOG2   word-address width; the memory holds 2**DEPTH_LOG2 words
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   req    access request, held high by the initiator until ack
//   we     1 = write, 0 = read
//   addr   byte address; bits [DEPTH_LOG2+1:2] select the word
//   wdata  write data
//   be     byte enables, be[0] covers wdata[7:0]
//   ack    one-cycle response strobe
//   rdata  read data, zero whenever ack is low
//   err    misaligned access flag, only meaningful with ack
//   stall  pipeline freeze for the initiator (req & ~ack)
//
// Build option
//   DMEM_BYTE_WRITE_EN  when defined, writes honour be. Otherwise every
//                       write updates the full word.

module data_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_LOG2  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  state_t                  state, state_nxt;
  logic [2:0]              cnt, cnt_nxt;
  logic                    accept;

  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   word_q;
  logic [1:0]              off_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wmask;
  logic                    misaligned;

  logic [31:0]             mem [0:(1 << DEPTH_LOG2) - 1];

  // Address bits above the word index are dropped, so addresses wrap.
  logic                    unused_inputs;

  assign accept = (state == IDLE) && req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt   = WAIT_LOAD;
          state_nxt = (WAIT_LOAD == 3'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
        if (cnt <= 3'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture. Inputs are ignored after acceptance.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      we_q    <= we;
      word_q  <= addr[DEPTH_LOG2+1:2];
      off_q   <= addr[1:0];
      wdata_q <= wdata;
    end
  end

`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0] be_q;

  always_ff @(posedge clk) begin
    if (reset && accept) begin
      be_q <= be;
    end
  end

  assign wmask         = be_q;
  assign unused_inputs = ^{addr[31:DEPTH_LOG2+2]};
`else
  assign wmask         = 4'hF;
  assign unused_inputs = ^{addr[31:DEPTH_LOG2+2], be};
`endif

  assign misaligned = (off_q != 2'b00);
  assign ack        = (state == RESP);
  assign err        = ack && misaligned;
  assign rdata      = (ack && !we_q && !misaligned) ? mem[word_q] : '0;
  assign stall      = req && !ack;

  // The write lands on the edge that ends RESP. A reset on that edge
  // abandons the access. Memory itself is never cleared.
  always_ff @(posedge clk) begin
    if (reset && ack && we_q && !misaligned) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        req0;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack, err, stall;
  logic [31:0] rdata;
  logic        ack0, err0, stall0;
  logic [31:0] rdata0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(6)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .ack(ack), .rdata(rdata), .err(err), .stall(stall)
  );

  data_mem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(6)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .ack(ack0), .rdata(rdata0), .err(err0), .stall(stall0)
  );

  typedef struct {
    string       name;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic        e;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives a request from the current time and follows it to ack.
  // exp_lat counts negedges from the call to the ack cycle.
  task automatic access(input string name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rd);
    int   n;
    logic got;
    logic wait_ok;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    n = 0; got = 1'b0; wait_ok = 1'b1;
    while (n < 20) begin
      #1;
      if (n > 0 && ack === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (n > 0 && (stall !== 1'b1 || rdata !== 32'h0)) wait_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!got) begin
      check({name, ".timeout"}, 32'(got), 32'd1);
    end else begin
      check({name, ".latency"}, 32'(n), 32'(exp_lat));
      check({name, ".err"}, 32'(err), 32'(exp_err));
      check({name, ".rdata"}, rdata, exp_rd);
      check({name, ".stall_at_ack"}, 32'(stall), 32'd0);
      check({name, ".waiting"}, 32'(wait_ok), 32'd1);
    end
  endtask

  initial begin
    int   n;
    logic got;

`ifdef DMEM_BYTE_WRITE_EN
    localparam logic [31:0] R_BE1  = 32'hDEADBEAA;
    localparam logic [31:0] R_BE0  = 32'hA5A5A5A5;
    localparam logic [31:0] R_BEC  = 32'hAABB0304;
`else
    localparam logic [31:0] R_BE1  = 32'h000000AA;
    localparam logic [31:0] R_BE0  = 32'h5A5A5A5A;
    localparam logic [31:0] R_BEC  = 32'hAABBCCDD;
`endif

    vecs[0]  = '{"wr_10",      1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{"rd_10",      1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{"wr_10_be1",  1'b1, 32'h10,  32'h000000AA, 4'h1, 1'b0, 32'h0};
    vecs[3]  = '{"rd_10_be1",  1'b0, 32'h10,  32'h0,        4'hF, 1'b0, R_BE1};
    vecs[4]  = '{"wr_13_mis",  1'b1, 32'h13,  32'h11111111, 4'hF, 1'b1, 32'h0};
    vecs[5]  = '{"rd_10_kept", 1'b0, 32'h10,  32'h0,        4'hF, 1'b0, R_BE1};
    vecs[6]  = '{"wr_110",     1'b1, 32'h110, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
    vecs[7]  = '{"rd_10_wrap", 1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hCAFEF00D};
    vecs[8]  = '{"rd_12_mis",  1'b0, 32'h12,  32'h0,        4'hF, 1'b1, 32'h0};
    vecs[9]  = '{"wr_20",      1'b1, 32'h20,  32'hA5A5A5A5, 4'hF, 1'b0, 32'h0};
    vecs[10] = '{"wr_20_be0",  1'b1, 32'h20,  32'h5A5A5A5A, 4'h0, 1'b0, 32'h0};
    vecs[11] = '{"rd_20",      1'b0, 32'h20,  32'h0,        4'hF, 1'b0, R_BE0};
    vecs[12] = '{"wr_fc",      1'b1, 32'hFC,  32'h01020304, 4'hF, 1'b0, 32'h0};
    vecs[13] = '{"wr_fc_beC",  1'b1, 32'hFC,  32'hAABBCCDD, 4'hC, 1'b0, 32'h0};

    // Reset state
    reset = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.rdata", rdata, 32'h0);
    check("rst.stall_lo", 32'(stall), 32'd0);
    check("rst.ack0", 32'(ack0), 32'd0);
    req = 1'b1;
    #1;
    check("rst.stall_follows_req", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    check("rst.no_accept", 32'(ack), 32'd0);
    req = 1'b0;
    reset = 1'b1;

    // Table-driven single accesses
    foreach (vecs[i]) begin
      @(negedge clk);
      access(vecs[i].name, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, 3, vecs[i].e, vecs[i].r);
      req = 1'b0;
    end
    @(negedge clk);
    access("rd_4fc_wrap", 1'b0, 32'h4FC, 32'h0, 4'hF, 3, 1'b0, R_BEC);
    req = 1'b0;

    // Back-to-back with req held: one bubble cycle between accesses
    @(negedge clk);
    access("b2b_wr_40", 1'b1, 32'h40, 32'h0BADCAFE, 4'hF, 3, 1'b0, 32'h0);
    access("b2b_rd_40", 1'b0, 32'h40, 32'h0, 4'hF, 4, 1'b0, 32'h0BADCAFE);
    req = 1'b0;

    // Inputs changed and req dropped after acceptance: the latched write completes
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h44; wdata = 32'h11223344; be = 4'hF;
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = 32'h41; wdata = 32'hFFFFFFFF; be = 4'h0;
    n = 1; got = 1'b0;
    while (n < 20) begin
      #1;
      if (ack === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    check("hold.ack_seen", 32'(got), 32'd1);
    check("hold.latency", 32'(n), 32'd3);
    check("hold.err", 32'(err), 32'd0);
    @(negedge clk);
    access("hold.rd_44", 1'b0, 32'h44, 32'h0, 4'hF, 3, 1'b0, 32'h11223344);
    req = 1'b0;

    // Reset in the WAIT cycle of a write: access abandoned
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h99999999; be = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ack === 1'b1) got = 1'b1;
      @(negedge clk);
    end
    check("rstmid.no_ack", 32'(got), 32'd0);
    access("rstmid.rd_40", 1'b0, 32'h40, 32'h0, 4'hF, 3, 1'b0, 32'h0BADCAFE);
    req = 1'b0;

    // Zero wait states: ack one cycle after acceptance
    @(negedge clk);
    req0 = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h5555AAAA; be = 4'hF;
    #1;
    check("w0.wr_ack_c0", 32'(ack0), 32'd0);
    @(negedge clk);
    #1;
    check("w0.wr_ack_c1", 32'(ack0), 32'd1);
    check("w0.wr_err", 32'(err0), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; we = 1'b0;
    #1;
    check("w0.rd_ack_c0", 32'(ack0), 32'd0);
    @(negedge clk);
    #1;
    check("w0.rd_ack_c1", 32'(ack0), 32'd1);
    check("w0.rd_data", rdata0, 32'h5555AAAA);
    req0 = 1'b0;
    @(negedge clk);
    #1;
    check("w0.rdata_idle", rdata0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2, which sets the number of wait states inserted before each response (legal range 0..7).
REQ-002 SHALL provide parameter DEPTH_LOG2, default 6, which sets the word-address width; memory depth is 2**DEPTH_LOG2 words of 32 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port req, input, 1, which is the initiator's access request and is held high until ack.
REQ-006 SHALL have port we, input, 1, which selects write (1) or read (0).
REQ-007 SHALL have port addr, input, 32, which is the byte address; bits [DEPTH_LOG2+1:2] select the word.
REQ-008 SHALL have port wdata, input, 32, which carries the write data.
REQ-009 SHALL have port be, input, 4, which carries the byte enables; be[0] covers wdata[7:0].
REQ-010 SHALL have port ack, output, 1, a one-cycle response strobe.
REQ-011 SHALL have port rdata, output, 32, which carries the read data and is valid only while ack=1.
REQ-012 SHALL have port err, output, 1, which flags a misaligned access and is valid only while ack=1.
REQ-013 SHALL have port stall, output, 1, which is high when req=1 and ack=0; it is the pipeline freeze for the initiator.

Function
REQ-014 SHALL implement the states IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1, SHALL latch addr, we, wdata and be, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to RESP in the cycle after the counter reaches 1.
REQ-017 In RESP, SHALL assert ack for exactly one cycle and then return to IDLE unconditionally.
REQ-018 Latency from the accepting edge to ack SHALL be WAIT_CYCLES+1 cycles.
REQ-019 Changes to the inputs after acceptance SHALL be ignored; the latched copies govern the access.
REQ-020 A read SHALL drive rdata from the latched word address during RESP; rdata SHALL be 0 whenever ack=0.
REQ-021 A write SHALL update memory at the clock edge ending RESP; the update SHALL affect only the bytes with be=1.
REQ-022 A write with be=0000 SHALL complete with ack and leave memory unchanged.
REQ-023 When latched addr[1:0]!=0, SHALL assert err with ack, suppress the write, and drive rdata=0.
REQ-024 Address bits above DEPTH_LOG2+1 SHALL be ignored, so addresses wrap modulo the memory size.
REQ-025 A req held high during the RESP cycle SHALL NOT be accepted; acceptance happens earliest in the following IDLE cycle, giving a one-cycle bubble.
REQ-026 A read issued after a completed write to the same word SHALL return the written data.
REQ-027 req going low in WAIT or RESP (a protocol violation) SHALL NOT abort the access; the access SHALL complete normally.

Reset
REQ-028 While reset=0 at a rising edge, SHALL set state to IDLE, the counter to 0, and ack and err to 0.
REQ-029 Reset asserted mid-access SHALL abandon the access with no write and no ack.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 stall SHALL follow req combinationally during reset, because ack=0 in reset.

Configuration
REQ-032 With macro DMEM_BYTE_WRITE_EN defined, SHALL honour be as in REQ-021 and REQ-022.
REQ-033 Without DMEM_BYTE_WRITE_EN, SHALL ignore be, make every write update the full 32-bit word, and still apply REQ-023.

Verification
REQ-034 WAIT_CYCLES=2; write addr=0x10, wdata=0xDEADBEEF, be=1111 -> ack high exactly 3 cycles after acceptance, err=0, stall high for those 3 cycles.
REQ-035 Read addr=0x10 after REQ-034 -> ack with rdata=0xDEADBEEF; one-cycle bubble between the two accesses when req is held high.
REQ-036 With the macro defined, write addr=0x10, wdata=0x000000AA, be=0001, then read -> rdata=0xDEADBEAA; without the macro -> rdata=0x000000AA.
REQ-037 Write addr=0x13 -> ack with err=1 and rdata=0; a read of addr=0x10 shows the word unchanged.
REQ-038 Write addr=0x110 with DEPTH_LOG2=6 -> word 4 updated, so a read of addr=0x10 returns the new data.
REQ-039 Pull reset low in the WAIT cycle of a write -> no ack, state IDLE; a later read shows the old contents; WAIT_CYCLES=0 gives ack 1 cycle after acceptance.
